// File: rtl/sig_host_port_if.sv
// sig_host_port_if
//   Bundles the core data-memory store signals and the signature stream
//   seen by the compliance test host.
//   master : drives addr/data_wr/wr (core side) and sig_ready (sink side)
//   slave  : the host responder; drives stall, the signature stream,
//            sig_count, halt and timeout
interface sig_host_port_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      addr;
  logic [31:0]      data_wr;
  logic             wr;
  logic             stall;
  logic             sig_valid;
  logic [31:0]      sig_data;
  logic             sig_ready;
  logic [CNT_W-1:0] sig_count;
  logic             halt;
  logic             timeout;

  modport master (
    output addr, data_wr, wr, sig_ready,
    input  stall, sig_valid, sig_data, sig_count, halt, timeout
  );

  modport slave (
    input  addr, data_wr, wr, sig_ready,
    output stall, sig_valid, sig_data, sig_count, halt, timeout
  );
endinterface

// File: rtl/sig_host_port.sv
// sig_host_port
//   Memory-mapped test-host responder for compliance runs. Stores to
//   SIG_ADDR are queued in a FIFO and streamed out on a valid/ready port;
//   a store to HALT_ADDR (or a watchdog expiry) drains the FIFO and then
//   raises a sticky halt.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sig_host_port_if.slave
//          addr/data_wr/wr (wr active-low store strobe), stall,
//          sig_valid/sig_data/sig_ready, sig_count, halt, timeout
module sig_host_port #(
  parameter logic [31:0] SIG_ADDR   = 32'h0000_0F00,
  parameter logic [31:0] HALT_ADDR  = 32'hCAFE_BEEF,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TIMEOUT    = 20000,
  parameter int          CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  sig_host_port_if.slave  bus
);

  localparam int               AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0] watchdog_q, watchdog_d;
  logic [CNT_W-1:0] sigCount_q, sigCount_d;
  logic             timeout_q, timeout_d;

  logic fifoEmpty;
  logic fifoFull;
  logic sigHit;
  logic haltHit;
  logic push;
  logic pop;
  logic sigValid;

  // Pointers carry one extra MSB so full and empty are distinguishable
  // when the index bits match.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  assign sigHit  = ~bus.wr && (bus.addr == SIG_ADDR)  && (state_q == RUN);
  assign haltHit = ~bus.wr && (bus.addr == HALT_ADDR) && (state_q == RUN);

  // Stall only looks at the current fullness; a pop in the same cycle does
  // not release it, which keeps sig_ready out of the combinational path.
  assign push     = sigHit && ~fifoFull;
  assign sigValid = ~fifoEmpty && (state_q != HALTED);
  assign pop      = sigValid && bus.sig_ready;

  assign bus.stall     = sigHit && fifoFull;
  assign bus.sig_valid = sigValid;
  assign bus.sig_data  = sigValid ? mem_q[rdPtr_q[AW-1:0]] : 32'h0;
  assign bus.sig_count = sigCount_q;
  assign bus.halt      = (state_q == HALTED);
  assign bus.timeout   = timeout_q;

  // Signature storage; contents are only visible through a valid head, so
  // the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= bus.data_wr;
    end
  end

  // Next-state for pointers and the saturating accepted-word counter.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    sigCount_d = sigCount_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
      if (sigCount_q != '1) begin
        sigCount_d = sigCount_q + CNT_ONE;
      end
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
  end

  // End-of-test sequencing. A halt store takes priority over a watchdog
  // expiry in the same cycle, so timeout only flags a genuine hang.
  always_comb begin
    state_d    = state_q;
    watchdog_d = watchdog_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      RUN: begin
        watchdog_d = watchdog_q + CNT_ONE;
        if (haltHit) begin
          state_d = DRAIN;
        end else if (watchdog_q == WD_LAST) begin
          state_d   = DRAIN;
          timeout_d = 1'b1;
        end
      end
      DRAIN: begin
        if (fifoEmpty) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // All control state; reset also flushes any queued words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      watchdog_q <= '0;
      sigCount_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      watchdog_q <= watchdog_d;
      sigCount_q <= sigCount_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sig_host_port.sv
// tb_sig_host_port
//   Self-checking bench for sig_host_port. A behavioural model keeps the
//   expected signature words in a queue: words are pushed when a store is
//   expected to be accepted and popped/compared when the sink handshakes.
module tb_sig_host_port;

  localparam int          DEPTH = 16;
  localparam int          TMO   = 50;
  localparam logic [31:0] SIGA  = 32'h0000_0F00;
  localparam logic [31:0] HALTA = 32'hCAFE_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sig_host_port_if #(.CNT_W(16)) bus ();

  sig_host_port #(
    .SIG_ADDR   (SIGA),
    .HALT_ADDR  (HALTA),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO),
    .CNT_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ [$];
  int          mState;
  int          mWd;
  int          mCount;
  logic        mTimeout;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock: check combinational outputs against the model at the falling
  // edge, then advance the model across the rising edge.
  task automatic step();
    logic        sigHit, haltHit, full, wasEmpty, expStall, expValid;
    logic        rdy;
    logic [31:0] wd;
    @(negedge clk);
    sigHit   = !bus.wr && (bus.addr == SIGA)  && (mState == 0);
    haltHit  = !bus.wr && (bus.addr == HALTA) && (mState == 0);
    full     = (expQ.size() == DEPTH);
    wasEmpty = (expQ.size() == 0);
    expStall = sigHit && full;
    expValid = (mState != 2) && !wasEmpty;
    rdy      = bus.sig_ready;
    wd       = bus.data_wr;
    checkOutput("stall",   32'(bus.stall),     32'(expStall));
    checkOutput("valid",   32'(bus.sig_valid), 32'(expValid));
    checkOutput("data",    bus.sig_data,       expValid ? expQ[0] : 32'h0);
    checkOutput("halt",    32'(bus.halt),      32'(mState == 2));
    checkOutput("timeout", 32'(bus.timeout),   32'(mTimeout));
    checkOutput("count",   32'(bus.sig_count), 32'(mCount));
    @(posedge clk);
    if (expValid && rdy) begin
      void'(expQ.pop_front());
    end
    if (sigHit && !full) begin
      expQ.push_back(wd);
      if (mCount != 65535) mCount++;
    end
    case (mState)
      0: begin
        if (haltHit) begin
          mState = 1;
        end else if (mWd == TMO - 1) begin
          mState   = 1;
          mTimeout = 1'b1;
        end
        mWd++;
      end
      1: if (wasEmpty) mState = 2;
      default: ;
    endcase
    #1;
  endtask

  task automatic applyStimulus(input logic doStore, input logic [31:0] a,
                               input logic [31:0] d, input logic ready);
    bus.wr        = ~doStore;
    bus.addr      = a;
    bus.data_wr   = d;
    bus.sig_ready = ready;
    step();
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, ready);
  endtask

  // Asserts reset away from a clock edge, checks outputs clear at once,
  // and releases just after a rising edge with the model cleared.
  task automatic resetDut();
    rst           = 1'b0;
    bus.wr        = 1'b1;
    bus.addr      = 32'h0;
    bus.data_wr   = 32'h0;
    bus.sig_ready = 1'b0;
    #2;
    checkOutput("rst_valid",   32'(bus.sig_valid), 32'h0);
    checkOutput("rst_data",    bus.sig_data,       32'h0);
    checkOutput("rst_halt",    32'(bus.halt),      32'h0);
    checkOutput("rst_timeout", 32'(bus.timeout),   32'h0);
    checkOutput("rst_stall",   32'(bus.stall),     32'h0);
    checkOutput("rst_count",   32'(bus.sig_count), 32'h0);
    expQ.delete();
    mState   = 0;
    mWd      = 0;
    mCount   = 0;
    mTimeout = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    resetDut();

    // In-order streaming with the sink always ready; loads and other
    // addresses must not enqueue anything.
    $display("[TB] streaming");
    applyStimulus(1'b1, SIGA, 32'h11, 1'b1);
    applyStimulus(1'b1, SIGA, 32'h22, 1'b1);
    applyStimulus(1'b0, SIGA, 32'h99, 1'b1);
    applyStimulus(1'b1, SIGA, 32'h33, 1'b1);
    applyStimulus(1'b1, 32'h104, 32'h77, 1'b1);
    applyStimulus(1'b1, SIGA, 32'h44, 1'b1);
    idle(3, 1'b1);
    checkOutput("t1_count", 32'(bus.sig_count), 32'd4);

    // Fill to capacity, then the 17th store stalls until a pop has landed.
    $display("[TB] full fifo");
    resetDut();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, SIGA, 32'h100 + i, 1'b0);
    applyStimulus(1'b1, SIGA, 32'h1FF, 1'b0);
    applyStimulus(1'b1, SIGA, 32'h1FF, 1'b1);
    applyStimulus(1'b1, SIGA, 32'h1FF, 1'b0);
    checkOutput("t2_count", 32'(bus.sig_count), 32'd17);
    idle(DEPTH, 1'b1);
    checkOutput("t2_empty", 32'(bus.sig_valid), 32'h0);

    // Halt store with words queued: halt waits for the drain.
    $display("[TB] halt drain");
    resetDut();
    applyStimulus(1'b1, SIGA, 32'hA1, 1'b0);
    applyStimulus(1'b1, SIGA, 32'hA2, 1'b0);
    applyStimulus(1'b1, SIGA, 32'hA3, 1'b0);
    applyStimulus(1'b1, HALTA, 32'h1, 1'b0);
    idle(3, 1'b0);
    checkOutput("t3_halt_wait", 32'(bus.halt), 32'h0);
    idle(3, 1'b1);
    checkOutput("t3_halt_pre", 32'(bus.halt), 32'h0);
    idle(1, 1'b1);
    checkOutput("t3_halt", 32'(bus.halt), 32'h1);
    checkOutput("t3_timeout", 32'(bus.timeout), 32'h0);

    // Watchdog expiry at the 50th edge; later signature stores are ignored.
    $display("[TB] watchdog");
    resetDut();
    applyStimulus(1'b1, SIGA, 32'hB1, 1'b0);
    applyStimulus(1'b1, SIGA, 32'hB2, 1'b0);
    idle(TMO - 3, 1'b0);
    checkOutput("t4_timeout_pre", 32'(bus.timeout), 32'h0);
    idle(1, 1'b0);
    checkOutput("t4_timeout", 32'(bus.timeout), 32'h1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, SIGA, 32'hC0 + i, 1'b1);
    checkOutput("t4_halt", 32'(bus.halt), 32'h1);
    checkOutput("t4_count", 32'(bus.sig_count), 32'd2);

    // Halt store on the very edge the watchdog would expire.
    $display("[TB] halt vs watchdog");
    resetDut();
    idle(TMO - 1, 1'b0);
    applyStimulus(1'b1, HALTA, 32'h0, 1'b0);
    idle(2, 1'b0);
    checkOutput("t5_timeout", 32'(bus.timeout), 32'h0);
    checkOutput("t5_halt", 32'(bus.halt), 32'h1);

    // Reset during drain with words still queued.
    $display("[TB] reset mid-drain");
    resetDut();
    applyStimulus(1'b1, SIGA, 32'hD1, 1'b0);
    applyStimulus(1'b1, SIGA, 32'hD2, 1'b0);
    applyStimulus(1'b1, SIGA, 32'hD3, 1'b0);
    applyStimulus(1'b1, HALTA, 32'h0, 1'b0);
    idle(2, 1'b0);
    checkOutput("t6_valid_pre", 32'(bus.sig_valid), 32'h1);
    resetDut();
    idle(2, 1'b1);
    checkOutput("t6_empty", 32'(bus.sig_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
